// File: rtl/countdown_sequencer_pkg.sv
// rtl/countdown_sequencer_pkg.sv - shared types and helpers for the countdown sequencer
// Purpose: FSM state encoding and the prescaler width helper.
// Ports: none (package).
package countdown_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Ceiling log2; the sequencer only uses it for n >= 2, so the result is >= 1.
    function automatic int presc_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/countdown_sequencer_prescaler.sv
// rtl/countdown_sequencer_prescaler.sv - free-running prescaler that paces Dec pulses
// Purpose: counts 0..PRESCALE-1 and wraps; held at zero while i_clear is high.
// Ports:
//   Clk          rising-edge clock
//   Rst_n        synchronous active-low reset
//   i_clear      forces the count to zero on the next edge
//   o_count      current count
//   o_tick       count is at its terminal value PRESCALE-1
//   o_tick_next  count is one below terminal (terminal next cycle unless cleared)
module dec_prescaler
    import countdown_sequencer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            i_clear,
    output logic [presc_width(PRESCALE)-1:0] o_count,
    output logic                            o_tick,
    output logic                            o_tick_next
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST     = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 2);

    logic [PW-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (!Rst_n || i_clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PW'(1);
        end
    end

    assign o_count     = r_count;
    assign o_tick      = (r_count == LAST);
    assign o_tick_next = (r_count == PRE_LAST);

endmodule

// File: rtl/countdown_sequencer.sv
// rtl/countdown_sequencer.sv - Load/Dec initiator driving an external down-counter
// Purpose: loads a count into the counter, issues prescaled Dec pulses, watches the
// returned value reach zero and cross-checks it against a shadow copy.
// Ports:
//   Clk, Rst_n   clock, synchronous active-low reset
//   Start        start request (sampled in IDLE only), StartValue count to load
//   Abort        cancel an operation in LOAD/RUN
//   CntLoad      counter Load pulse, CntDec counter Dec pulse, CntData counter DataIn
//   CntValue     counter DataOut
//   Busy         high in LOAD/RUN/DONE
//   Done, Fault, Aborted   one-cycle status pulses
module countdown_sequencer
    import countdown_sequencer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] StartValue,
    input  logic             Abort,
    output logic             CntLoad,
    output logic             CntDec,
    output logic [WIDTH-1:0] CntData,
    input  logic [WIDTH-1:0] CntValue,
    output logic             Busy,
    output logic             Done,
    output logic             Fault,
    output logic             Aborted
);

    localparam int PW = presc_width(PRESCALE);

    generate
        if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
            $error("countdown_sequencer: PRESCALE must be within 2..256");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next_state;
    logic             w_abort_take;
    logic             w_accept;
    logic             w_check;
    logic [PW-1:0]    w_presc_count;
    logic             w_presc_tick;
    logic             w_presc_tick_next;

    logic             r_cnt_load;
    logic             r_cnt_dec;
    logic [WIDTH-1:0] r_cnt_data;
    logic [WIDTH-1:0] r_shadow;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;
    logic             r_aborted;

    // Prescaler only advances in RUN, so it always enters RUN at zero.
    dec_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .i_clear     (r_state != ST_RUN),
        .o_count     (w_presc_count),
        .o_tick      (w_presc_tick),
        .o_tick_next (w_presc_tick_next)
    );

    assign w_accept = (r_state == ST_IDLE) && Start;
    // Check cycle: first RUN cycle and the cycle after each Dec, when the counter
    // output has settled to the value matching the shadow.
    assign w_check  = (w_presc_count == '0);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_abort_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (Abort) begin
                    w_next_state = ST_IDLE;
                    w_abort_take = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over both mismatch and zero-detect.
                if (Abort) begin
                    w_next_state = ST_IDLE;
                    w_abort_take = 1'b1;
                end else if (w_check) begin
                    if (CntValue != r_shadow) begin
                        w_next_state = ST_FAULT;
                    end else if (CntValue == '0) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_FAULT: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up with
    // the cycle spent in the corresponding state.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt_load <= 1'b0;
            r_cnt_dec  <= 1'b0;
            r_cnt_data <= '0;
            r_shadow   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_cnt_load <= (w_next_state == ST_LOAD);
            r_cnt_dec  <= (r_state == ST_RUN) && (w_next_state == ST_RUN) && w_presc_tick_next;
            r_busy     <= (w_next_state == ST_LOAD) || (w_next_state == ST_RUN)
                          || (w_next_state == ST_DONE);
            r_done     <= (w_next_state == ST_DONE);
            r_fault    <= (w_next_state == ST_FAULT);
            r_aborted  <= w_abort_take;
            if (w_accept) begin
                r_cnt_data <= StartValue;
                r_shadow   <= StartValue;
            end else if ((r_state == ST_RUN) && w_presc_tick) begin
                // The counter decrements on this same edge because CntDec is high now.
                r_shadow   <= r_shadow - WIDTH'(1);
            end
        end
    end

    assign CntLoad = r_cnt_load;
    assign CntDec  = r_cnt_dec;
    assign CntData = r_cnt_data;
    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Fault   = r_fault;
    assign Aborted = r_aborted;

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Initiator side of the Load/Dec down-counter interface. It accepts a start request carrying a count, loads the external down-counter, then issues Dec pulses at a prescaled rate. It watches the returned count until it reaches zero and reports completion. A shadow count cross-checks the counter and flags a fault on any mismatch. It sits between control logic and a down-counter instance, and is the only driver of that counter's Load, Dec and DataIn pins.

Parameters:
WIDTH, 4, width of count value (matches counter data width)
PRESCALE, 4, clock cycles per Dec pulse; legal range 2..256 (elaboration error otherwise)

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  synchronous active-low reset
Start  input  1  start request; sampled only in IDLE
StartValue  input  WIDTH  count to load; captured when Start is accepted
Abort  input  1  cancels an operation in LOAD/RUN
CntLoad  output  1  to counter Load; one-cycle pulse
CntDec  output  1  to counter Dec; one-cycle pulse every PRESCALE cycles in RUN
CntData  output  WIDTH  to counter DataIn; holds captured StartValue
CntValue  input  WIDTH  from counter DataOut
Busy  output  1  high in LOAD, RUN, DONE
Done  output  1  one-cycle pulse on normal completion
Fault  output  1  one-cycle pulse on CntValue/shadow mismatch
Aborted  output  1  one-cycle pulse when Abort is taken

Behaviour:
- All outputs are registered. Reset (Rst_n low at an edge) gives state IDLE and clears CntLoad, CntDec, CntData, Busy, Done, Fault, Aborted, the prescaler and the shadow count. Reset has priority over everything, including mid-RUN.
- The counter itself has no reset. After a reset, CntValue is don't-care until the next LOAD.
- States: IDLE, LOAD, RUN, DONE, FAULT.
- IDLE: Start=1 moves to LOAD. On the same edge, StartValue is latched into CntData and into shadow. Abort is ignored in IDLE.
- LOAD (1 cycle): CntLoad=1. Always moves to RUN, with prescaler cleared to 0.
- RUN: the prescaler counts 0..PRESCALE-1 and wraps. CntDec=1 exactly when prescaler==PRESCALE-1. Shadow decrements on the same edge.
- Check cycle = RUN cycle with prescaler==0, which is the first RUN cycle and the cycle after each Dec.
  - If CntValue!=shadow, go to FAULT.
  - Else if CntValue==0, go to DONE. No further Dec is issued, so there is no wrap below zero.
- Start is ignored while Busy. StartValue changes are ignored after capture.
- DONE (1 cycle): Done=1, then IDLE.
- FAULT (1 cycle): Fault=1, then IDLE.
- Abort in LOAD or RUN goes to IDLE next edge with Aborted=1 for that cycle. No Done, no Fault, no further CntDec.
- Abort beats zero-detect and mismatch in the same cycle.
- Latency for value V: Start accepted at cycle 0, CntLoad at cycle 1, RUN cycles 2..V*PRESCALE+2, Done at cycle V*PRESCALE+3. Exactly V CntDec pulses.
- V=0: RUN lasts one cycle, Done at cycle 3, zero CntDec.
- Widths: shadow and prescaler are unsigned. Prescaler width is clog2(PRESCALE).

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN, DONE, FAULT) and a prescaler-width function (clog2).
- One natural sub-module, dec_prescaler: a free counter with clear and a terminal-tick output, used to generate CntDec.
- The bench instantiates the existing down-counter as the CntValue source. A fault-injection mode forces CntValue.

Test Plan:
- PRESCALE=4, Start with StartValue=3 at cycle 0 -> CntLoad at cycle 1; CntDec at cycles 5, 9, 13; Done at cycle 15; Busy low from cycle 16; CntValue ends at 0.
- StartValue=0 -> CntLoad at cycle 1, no CntDec, Done at cycle 3.
- StartValue=15, Abort at cycle 20 -> Aborted at the next cycle, no Done, no CntDec after cycle 20, IDLE after.
- Start pulsed again at cycle 6 during a run, with StartValue=9 -> ignored; CntData stays at the original value; completion timing unchanged.
- StartValue=5, bench forces CntValue to 7 at the second check cycle -> Fault pulse, no Done, IDLE next.
- Rst_n low at cycle 8 mid-RUN -> all outputs 0 after that edge; Start at cycle 10 with StartValue=2 -> normal run, Done at cycle 10+11=21.
